// File: rtl/ppr_rank_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ppr_rank_sequencer                                                |
// | Turns per-rank ppr_en levels into the DRAM soft-PPR command sequence on a  |
// | valid/ready port, one rank at a time, and returns done/status pulses.      |
// | Option : define PPR_GUARD_KEY_EN to insert the 4-MRW guard-key sequence.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module ppr_rank_sequencer #(
  parameter int NB_RANK   = 2,
  parameter int BA_WIDTH  = 8,
  parameter int ROW_WIDTH = 16,
  parameter int T_MRD     = 4,
  parameter int T_PGM     = 32,
  parameter int T_PGMEXIT = 8
) (
  input  logic                 pclk_i,
  input  logic                 prst_i,
  input  logic [NB_RANK-1:0]   ppr_en_i,
  input  logic [BA_WIDTH-1:0]  ppr_bank_i,
  input  logic [ROW_WIDTH-1:0] ppr_row_i,
  input  logic                 ppr_fail_i,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [1:0]           cmd_type_o,
  output logic [NB_RANK-1:0]   cmd_rank_o,
  output logic [BA_WIDTH-1:0]  cmd_bank_o,
  output logic [ROW_WIDTH-1:0] cmd_addr_o,
  output logic [NB_RANK-1:0]   ppr_done_o,
  output logic [NB_RANK-1:0]   ppr_status_o,
  output logic                 busy_o
);

  localparam int c_TMAX0 = (T_PGM > T_MRD) ? T_PGM : T_MRD;
  localparam int c_TMAX  = (c_TMAX0 > T_PGMEXIT) ? c_TMAX0 : T_PGMEXIT;
  localparam int c_CW    = (c_TMAX < 1) ? 1 : $clog2(c_TMAX + 1);

  // Counter reload values: the next command issues (reload + 1) cycles after
  // the accepting edge, so MRW gets T_MRD fully idle cycles.
  localparam logic [c_CW-1:0] c_L_MRD  = c_CW'(T_MRD);
  localparam logic [c_CW-1:0] c_L_PGM  = c_CW'((T_PGM > 0) ? T_PGM - 1 : 0);
  localparam logic [c_CW-1:0] c_L_EXIT = c_CW'((T_PGMEXIT > 0) ? T_PGMEXIT - 1 : 0);

  localparam logic [1:0] c_CMD_MRW = 2'd1;
  localparam logic [1:0] c_CMD_ACT = 2'd2;
  localparam logic [1:0] c_CMD_PRE = 2'd3;

  localparam logic [BA_WIDTH-1:0]  c_MR_PPR  = BA_WIDTH'(4);
  localparam logic [ROW_WIDTH-1:0] c_PPR_ON  = ROW_WIDTH'(16'h0020);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MRW_EN,
`ifdef PPR_GUARD_KEY_EN
    S_GUARD,
`endif
    S_ACT,
    S_PRE,
    S_MRW_DIS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               r_ret;
  logic [c_CW-1:0]      r_cnt;
  logic [NB_RANK-1:0]   r_en_q;
  logic [NB_RANK-1:0]   r_pending;
  logic [NB_RANK-1:0]   r_rank;
  logic [BA_WIDTH-1:0]  r_bank;
  logic [ROW_WIDTH-1:0] r_row;
  logic                 r_fail;
  logic                 r_valid;
  logic [1:0]           r_cmd_type;
  logic [NB_RANK-1:0]   r_cmd_rank;
  logic [BA_WIDTH-1:0]  r_cmd_bank;
  logic [ROW_WIDTH-1:0] r_cmd_addr;
  logic [NB_RANK-1:0]   r_done;
  logic [NB_RANK-1:0]   r_status;
  logic                 r_busy;
`ifdef PPR_GUARD_KEY_EN
  logic [1:0]           r_gidx;
`endif

  logic [NB_RANK-1:0]   w_rise;
  logic [NB_RANK-1:0]   w_fall;
  logic [NB_RANK-1:0]   w_pend_eff;
  logic [NB_RANK-1:0]   w_grant;
  logic [NB_RANK-1:0]   w_take;
  logic [1:0]           w_nx_type;
  logic [BA_WIDTH-1:0]  w_nx_bank;
  logic [ROW_WIDTH-1:0] w_nx_addr;

  assign w_rise     = ppr_en_i & ~r_en_q;
  assign w_fall     = ~ppr_en_i & r_en_q;
  // A request whose level drops this cycle is cancelled, never granted.
  assign w_pend_eff = r_pending & ~w_fall;
  assign w_grant    = w_pend_eff & (~w_pend_eff + NB_RANK'(1));
  assign w_take     = (r_state == S_IDLE) ? w_grant : '0;

  always_comb begin
    w_nx_type = c_CMD_MRW;
    w_nx_bank = c_MR_PPR;
    w_nx_addr = '0;
    case (r_ret)
`ifdef PPR_GUARD_KEY_EN
      S_GUARD: begin
        w_nx_bank = '0;
        case (r_gidx)
          2'd0:    w_nx_addr = ROW_WIDTH'(16'h0CFF);
          2'd1:    w_nx_addr = ROW_WIDTH'(16'h07FF);
          2'd2:    w_nx_addr = ROW_WIDTH'(16'h0BFF);
          default: w_nx_addr = ROW_WIDTH'(16'h03FF);
        endcase
      end
`endif
      S_ACT: begin
        w_nx_type = c_CMD_ACT;
        w_nx_bank = r_bank;
        w_nx_addr = r_row;
      end
      S_PRE: begin
        w_nx_type = c_CMD_PRE;
        w_nx_bank = r_bank;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      r_state    <= S_IDLE;
      r_ret      <= S_IDLE;
      r_cnt      <= '0;
      r_en_q     <= '0;
      r_pending  <= '0;
      r_rank     <= '0;
      r_bank     <= '0;
      r_row      <= '0;
      r_fail     <= 1'b0;
      r_valid    <= 1'b0;
      r_cmd_type <= '0;
      r_cmd_rank <= '0;
      r_cmd_bank <= '0;
      r_cmd_addr <= '0;
      r_done     <= '0;
      r_status   <= '0;
      r_busy     <= 1'b0;
`ifdef PPR_GUARD_KEY_EN
      r_gidx     <= '0;
`endif
    end else begin
      r_en_q    <= ppr_en_i;
      r_pending <= (r_pending & ~w_fall & ~w_take) | w_rise;
      r_done    <= '0;
      r_status  <= '0;
      if (r_state != S_IDLE)
        r_fail <= r_fail | ppr_fail_i;

      case (r_state)
        S_IDLE: begin
          if (|w_pend_eff) begin
            r_rank     <= w_grant;
            r_bank     <= ppr_bank_i;
            r_row      <= ppr_row_i;
            r_fail     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_MRW_EN;
            r_valid    <= 1'b1;
            r_cmd_type <= c_CMD_MRW;
            r_cmd_rank <= w_grant;
            r_cmd_bank <= c_MR_PPR;
            r_cmd_addr <= c_PPR_ON;
`ifdef PPR_GUARD_KEY_EN
            r_gidx     <= '0;
`endif
          end
        end

        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CW'(1);
          end else if (r_ret == S_DONE) begin
            r_state  <= S_DONE;
            r_done   <= r_rank;
            r_status <= (r_fail | ppr_fail_i) ? '0 : r_rank;
          end else begin
            r_state    <= r_ret;
            r_valid    <= 1'b1;
            r_cmd_type <= w_nx_type;
            r_cmd_rank <= r_rank;
            r_cmd_bank <= w_nx_bank;
            r_cmd_addr <= w_nx_addr;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          // Command states: hold fields until accepted, then start the wait.
          if (cmd_ready_i) begin
            r_valid    <= 1'b0;
            r_cmd_type <= '0;
            r_cmd_rank <= '0;
            r_cmd_bank <= '0;
            r_cmd_addr <= '0;
            r_state    <= S_WAIT;
            case (r_state)
              S_MRW_EN: begin
                r_cnt <= c_L_MRD;
`ifdef PPR_GUARD_KEY_EN
                r_ret <= S_GUARD;
`else
                r_ret <= S_ACT;
`endif
              end
`ifdef PPR_GUARD_KEY_EN
              S_GUARD: begin
                r_cnt  <= c_L_MRD;
                r_gidx <= r_gidx + 2'd1;
                r_ret  <= (r_gidx == 2'd3) ? S_ACT : S_GUARD;
              end
`endif
              S_ACT: begin
                r_cnt <= c_L_PGM;
                r_ret <= S_PRE;
              end
              S_PRE: begin
                r_cnt <= c_L_EXIT;
                r_ret <= S_MRW_DIS;
              end
              default: begin
                r_cnt <= c_L_MRD;
                r_ret <= S_DONE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign cmd_valid_o  = r_valid;
  assign cmd_type_o   = r_cmd_type;
  assign cmd_rank_o   = r_cmd_rank;
  assign cmd_bank_o   = r_cmd_bank;
  assign cmd_addr_o   = r_cmd_addr;
  assign ppr_done_o   = r_done;
  assign ppr_status_o = r_status;
  assign busy_o       = r_busy;

endmodule
`default_nettype wire
